// File: rtl/mac_pin_driver.sv
// Host-side sequencer for the 8-bit MAC core: streams operand pairs into the
// MAC pins, reads back the 16-bit accumulator at frame end and clears the MAC.
module mac_pin_driver #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_a,
  input  logic [7:0]  s_b,
  input  logic        s_last,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [15:0] r_data,
  output logic [7:0]  r_count,
  output logic [7:0]  pin_ui,
  output logic [7:0]  pin_uio,
  input  logic [7:0]  pin_uo,
  output logic        pin_ena
);

  typedef enum logic [2:0] {
    CLEAR, IDLE, LOAD_A, MAC, SETTLE, RD_LO, RD_HI, RESULT
  } state_t;

  state_t      state, next_state;
  logic [7:0]  b_q;
  logic        last_q;
  logic [7:0]  pair_cnt;
  logic [3:0]  settle_cnt;
  logic        hi_wait;
  logic [7:0]  ui_d;
  logic [7:0]  uio_d;
  logic        accept;
  logic        consume;

  assign accept  = s_valid && s_ready;
  assign consume = r_valid && r_ready;

  // CLEAR leaves only once the clear strobe has actually been on the pins,
  // so the cycle right after reset release is a real clear cycle.
  always_comb begin
    next_state = state;
    case (state)
      CLEAR:   if (pin_uio[2]) next_state = IDLE;
      IDLE:    if (accept) next_state = LOAD_A;
      LOAD_A:  next_state = MAC;
      MAC:     next_state = last_q ? SETTLE : IDLE;
      SETTLE:  if (settle_cnt == 4'd1) next_state = RD_LO;
      RD_LO:   next_state = RD_HI;
      RD_HI:   if (hi_wait) next_state = RESULT;
      RESULT:  if (consume) next_state = CLEAR;
      default: next_state = CLEAR;
    endcase
  end

  // Pin values are decoded from the state being entered so they line up
  // with that state's cycle once registered.
  always_comb begin
    ui_d  = 8'd0;
    uio_d = 8'd0;
    case (next_state)
      CLEAR:  uio_d[2] = 1'b1;
      LOAD_A: begin
        ui_d     = s_a;
        uio_d[0] = 1'b1;
      end
      MAC: begin
        ui_d     = b_q;
        uio_d[1] = 1'b1;
      end
      RD_HI:  uio_d[3] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR;
      b_q        <= 8'd0;
      last_q     <= 1'b0;
      pair_cnt   <= 8'd0;
      settle_cnt <= 4'd0;
      hi_wait    <= 1'b0;
      s_ready    <= 1'b0;
      r_valid    <= 1'b0;
      r_data     <= 16'd0;
      r_count    <= 8'd0;
      pin_ui     <= 8'd0;
      pin_uio    <= 8'd0;
      pin_ena    <= 1'b0;
    end else begin
      state   <= next_state;
      pin_ena <= 1'b1;
      pin_ui  <= ui_d;
      pin_uio <= uio_d;
      s_ready <= (next_state == IDLE);
      // r_valid follows the RESULT state a cycle later, after both bytes landed.
      r_valid <= (state == RESULT) && !consume;

      if (accept) begin
        b_q    <= s_b;
        last_q <= s_last;
        if (pair_cnt != 8'hFF) pair_cnt <= pair_cnt + 8'd1;
      end else if (state == CLEAR) begin
        pair_cnt <= 8'd0;
      end

      if (state == MAC) settle_cnt <= 4'(SETTLE_CYCLES);
      else if (state == SETTLE) settle_cnt <= settle_cnt - 4'd1;

      hi_wait <= (state == RD_HI) && !hi_wait;

      if (state == RD_LO) r_data[7:0] <= pin_uo;
      if (state == RD_HI && hi_wait) begin
        r_data[15:8] <= pin_uo;
        r_count      <= pair_cnt;
      end
    end
  end

endmodule

// File: tb/tb_mac_pin_driver.sv
// Self-checking bench for mac_pin_driver: a behavioural MAC core on the pins,
// directed test-plan frames plus random frames checked against plain arithmetic.
module tb_mac_pin_driver;

  localparam int SETTLE = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_a = 8'd0;
  logic [7:0]  s_b = 8'd0;
  logic        s_last = 1'b0;
  logic        r_valid;
  logic        r_ready = 1'b0;
  logic [15:0] r_data;
  logic [7:0]  r_count;
  logic [7:0]  pin_ui;
  logic [7:0]  pin_uio;
  logic [7:0]  pin_uo;
  logic        pin_ena;

  int checks = 0;
  int errors = 0;
  int accepts = 0;
  int clears = 0;
  int cyc = 0;
  int strobe_violations = 0;

  logic [7:0]  mac_a = 8'd0;
  logic [15:0] mac_acc = 16'd0;
  logic [7:0]  mac_uo = 8'd0;
  logic [7:0]  qa[$];
  logic [7:0]  qb[$];

  mac_pin_driver #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_count(r_count),
    .pin_ui(pin_ui), .pin_uio(pin_uio), .pin_uo(pin_uo), .pin_ena(pin_ena)
  );

  always #5 clk = ~clk;

  // Behavioural MAC core: strobes act on the edge, readback lags rd_sel by one cycle.
  assign pin_uo = mac_uo;
  always @(posedge clk) begin
    mac_uo <= pin_uio[3] ? mac_acc[15:8] : mac_acc[7:0];
    if (pin_uio[0]) mac_a <= pin_ui;
    if (pin_uio[1]) mac_acc <= mac_acc + {8'd0, mac_a} * {8'd0, pin_ui};
    if (pin_uio[2]) mac_acc <= 16'd0;
    cyc <= cyc + 1;
    if (s_valid && s_ready) accepts <= accepts + 1;
    if (pin_uio[2]) clears <= clears + 1;
    if ($countones(pin_uio[2:0]) > 1 || pin_uio[7:4] != 4'd0)
      strobe_violations <= strobe_violations + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Offers one pair from a negedge and returns on the negedge after its accept edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic last,
                               output bit done, output int acc_cyc);
    done = 1'b0;
    s_a = a;
    s_b = b;
    s_last = last;
    s_valid = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      if (s_ready) begin
        @(posedge clk);
        done = 1'b1;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic doReset(input string tag);
    rst_n = 1'b0;
    #1;
    checkOutput({tag, " rst s_ready"}, s_ready, 0);
    checkOutput({tag, " rst r_valid"}, r_valid, 0);
    checkOutput({tag, " rst pins"}, {pin_ena, pin_ui, pin_uio}, 0);
    checkOutput({tag, " rst result"}, {r_data, r_count}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput({tag, " clear pulse"}, pin_uio, 8'h04);
    checkOutput({tag, " ena"}, pin_ena, 1);
    checkOutput({tag, " ready after 1 edge"}, s_ready, 0);
    @(negedge clk);
    checkOutput({tag, " ready after 2 edges"}, s_ready, 1);
    checkOutput({tag, " idle pins"}, pin_uio, 0);
  endtask

  task automatic getResult(input string tag, input logic [15:0] exp_data,
                           input logic [7:0] exp_count, input int hold, input bit toggle);
    int n = 0;
    bit saw_ready = 1'b0;
    bit stable = 1'b1;
    int acc0;
    int clr0;
    while (!r_valid && n < 100) begin
      if (s_ready) saw_ready = 1'b1;
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " latency"}, n, 6 + SETTLE);
    checkOutput({tag, " data"}, r_data, exp_data);
    checkOutput({tag, " count"}, r_count, exp_count);
    acc0 = accepts;
    for (int i = 0; i < hold; i++) begin
      if (toggle) s_valid = i[0];
      @(negedge clk);
      if (!(r_valid === 1'b1 && r_data === exp_data && r_count === exp_count && pin_uio === 8'd0))
        stable = 1'b0;
      if (s_ready) saw_ready = 1'b1;
    end
    s_valid = 1'b0;
    if (hold > 0) begin
      checkOutput({tag, " hold stable"}, stable, 1);
      checkOutput({tag, " ignored s_valid"}, accepts, acc0);
    end
    checkOutput({tag, " s_ready low"}, saw_ready, 0);
    clr0 = clears;
    r_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    r_ready = 1'b0;
    checkOutput({tag, " r_valid drop"}, r_valid, 0);
    checkOutput({tag, " clear strobe"}, pin_uio, 8'h04);
    checkOutput({tag, " s_ready in clear"}, s_ready, 0);
    @(negedge clk);
    checkOutput({tag, " s_ready back"}, s_ready, 1);
    repeat (3) @(negedge clk);
    checkOutput({tag, " one clear"}, clears - clr0, 1);
  endtask

  // Sends the queued pairs back to back; expectations come from plain arithmetic.
  task automatic runFrame(input string tag, input int hold, input bit toggle);
    int sum = 0;
    int n = qa.size();
    int prev = 0;
    int c;
    bit d;
    bit ok_acc = 1'b1;
    bit ok_space = 1'b1;
    for (int i = 0; i < n; i++) begin
      applyStimulus(qa[i], qb[i], i == n - 1, d, c);
      ok_acc &= d;
      if (i > 0 && c - prev != 3) ok_space = 1'b0;
      prev = c;
      sum += int'(qa[i]) * int'(qb[i]);
    end
    checkOutput({tag, " accepted"}, ok_acc, 1);
    if (n > 1) checkOutput({tag, " spacing"}, ok_space, 1);
    getResult(tag, 16'(sum % 65536), (n > 255) ? 8'd255 : 8'(n), hold, toggle);
    qa.delete();
    qb.delete();
  endtask

  initial begin
    bit d;
    int c;
    @(negedge clk);
    doReset("init");

    qa.push_back(8'd3); qb.push_back(8'd4);
    runFrame("single", 0, 1'b0);

    qa.push_back(8'd3); qb.push_back(8'd4);
    qa.push_back(8'd5); qb.push_back(8'd6);
    runFrame("multi", 0, 1'b0);

    qa.push_back(8'd255); qb.push_back(8'd255);
    qa.push_back(8'd255); qb.push_back(8'd255);
    runFrame("wrap", 0, 1'b0);

    qa.push_back(8'd10); qb.push_back(8'd11);
    runFrame("backpressure", 10, 1'b0);

    applyStimulus(8'd7, 8'd9, 1'b0, d, c);
    checkOutput("midreset accepted", d, 1);
    @(negedge clk);
    checkOutput("midreset mac strobe", pin_uio, 8'h02);
    doReset("midreset");
    qa.push_back(8'd2); qb.push_back(8'd2);
    runFrame("after reset", 0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      qa.push_back(8'd1);
      qb.push_back(8'd1);
    end
    runFrame("saturate", 6, 1'b1);

    for (int f = 0; f < 6; f++) begin
      int n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        qa.push_back(8'($urandom));
        qb.push_back(8'($urandom));
      end
      runFrame($sformatf("random%0d", f), $urandom_range(0, 3), 1'b1);
    end

    checkOutput("strobe exclusivity", strobe_violations, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
